// File: rtl/i2c_target_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_target_ctrl_if
//  Description : Pad levels plus byte-wide register port of the I2C target.
//  Revision    : 1.0 - initial release
// ============================================================================
interface i2c_target_ctrl_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       busy;

    modport slave (
        input  scl_i, sda_i, rd_data,
        output sda_oe, reg_addr, wr_en, wr_data, rd_en, busy
    );

    modport master (
        output scl_i, sda_i, rd_data,
        input  sda_oe, reg_addr, wr_en, wr_data, rd_en, busy
    );
endinterface
`default_nettype wire

// File: rtl/i2c_target_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_target_ctrl
//  Description : I2C target bridging transfers to a byte register port with
//                an auto-incrementing 8-bit pointer. Never stretches SCL.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_target_ctrl #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    i2c_target_ctrl_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_ADDR_ACK  = 4'd2,
        S_PTR       = 4'd3,
        S_PTR_ACK   = 4'd4,
        S_WDATA     = 4'd5,
        S_WDATA_ACK = 4'd6,
        S_RDATA     = 4'd7,
        S_RDATA_ACK = 4'd8,
        S_IGNORE    = 4'd9
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_hist;
    logic                   r_sda_hist;
    logic                   w_scl_s;
    logic                   w_sda_s;
    logic                   w_scl_rise;
    logic                   w_scl_fall;
    logic                   w_start;
    logic                   w_stop;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [6:0] r_rx_sh, w_rx_nxt;
    logic [7:0] r_tx_sh, w_tx_nxt;
    logic       r_sda_oe, w_oe_nxt;
    logic [7:0] r_reg_addr, w_addr_nxt;
    logic       r_wr_en, w_wr_en_nxt;
    logic [7:0] r_wr_data, w_wr_data_nxt;
    logic       r_rd_en, w_rd_en_nxt;
    logic       r_rd_dly;
    logic       r_busy, w_busy_nxt;
    logic [7:0] w_rx_byte;

    // Synchronizers and history flops idle at 1, matching a released bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_hist <= 1'b1;
            r_sda_hist <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], bus.scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], bus.sda_i};
            r_scl_hist <= r_scl_sync[SYNC_STAGES-1];
            r_sda_hist <= r_sda_sync[SYNC_STAGES-1];
        end
    end

    assign w_scl_s    = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_s    = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl_s & ~r_scl_hist;
    assign w_scl_fall = ~w_scl_s & r_scl_hist;
    assign w_start    = w_scl_s & r_scl_hist & r_sda_hist & ~w_sda_s;
    assign w_stop     = w_scl_s & r_scl_hist & ~r_sda_hist & w_sda_s;
    assign w_rx_byte  = {r_rx_sh, w_sda_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 3'd0;
            r_rx_sh    <= 7'd0;
            r_tx_sh    <= 8'd0;
            r_sda_oe   <= 1'b0;
            r_reg_addr <= 8'd0;
            r_wr_en    <= 1'b0;
            r_wr_data  <= 8'd0;
            r_rd_en    <= 1'b0;
            r_rd_dly   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_rx_sh    <= w_rx_nxt;
            r_tx_sh    <= w_tx_nxt;
            r_sda_oe   <= w_oe_nxt;
            r_reg_addr <= w_addr_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_rd_en    <= w_rd_en_nxt;
            r_rd_dly   <= r_rd_en;
            r_busy     <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_rx_nxt      = r_rx_sh;
        w_tx_nxt      = r_rd_dly ? bus.rd_data : r_tx_sh;
        w_oe_nxt      = r_sda_oe;
        w_addr_nxt    = r_wr_en ? r_reg_addr + 8'd1 : r_reg_addr;
        w_wr_en_nxt   = 1'b0;
        w_wr_data_nxt = r_wr_data;
        w_rd_en_nxt   = 1'b0;
        w_busy_nxt    = r_busy;

        if (w_stop) begin
            w_state_nxt = S_IDLE;
            w_oe_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
        end else if (w_start) begin
            w_state_nxt   = S_ADDR;
            w_bit_cnt_nxt = 3'd0;
            w_oe_nxt      = 1'b0;
            w_busy_nxt    = 1'b0;
        end else begin
            unique case (r_state)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (w_scl_rise) begin
                        w_rx_nxt      = w_rx_byte[6:0];
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            if (r_state == S_ADDR) begin
                                if (w_rx_byte[7:1] == TARGET_ADDR) begin
                                    w_state_nxt = S_ADDR_ACK;
                                    w_busy_nxt  = 1'b1;
                                    w_rd_en_nxt = w_rx_byte[0];
                                end else begin
                                    w_state_nxt = S_IGNORE;
                                end
                            end else if (r_state == S_PTR) begin
                                w_addr_nxt  = w_rx_byte;
                                w_state_nxt = S_PTR_ACK;
                            end else begin
                                w_wr_data_nxt = w_rx_byte;
                                w_wr_en_nxt   = 1'b1;
                                w_state_nxt   = S_WDATA_ACK;
                            end
                        end
                    end
                end
                // First fall asserts ACK, second fall ends it; r_rx_sh[0] still holds R/W.
                S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_sda_oe) begin
                            w_oe_nxt = 1'b1;
                        end else begin
                            w_bit_cnt_nxt = 3'd0;
                            if (r_state == S_ADDR_ACK && r_rx_sh[0]) begin
                                w_state_nxt = S_RDATA;
                                w_oe_nxt    = ~r_tx_sh[7];
                                w_tx_nxt    = {r_tx_sh[6:0], 1'b0};
                            end else begin
                                w_oe_nxt    = 1'b0;
                                w_state_nxt = (r_state == S_ADDR_ACK) ? S_PTR : S_WDATA;
                            end
                        end
                    end
                end
                S_RDATA: begin
                    if (w_scl_fall) begin
                        w_oe_nxt = ~r_tx_sh[7];
                        w_tx_nxt = {r_tx_sh[6:0], 1'b0};
                    end else if (w_scl_rise) begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_state_nxt = S_RDATA_ACK;
                        end
                    end
                end
                S_RDATA_ACK: begin
                    if (w_scl_fall) begin
                        w_oe_nxt   = 1'b0;
                        w_addr_nxt = r_reg_addr + 8'd1;
                    end else if (w_scl_rise) begin
                        if (!w_sda_s) begin
                            w_rd_en_nxt   = 1'b1;
                            w_bit_cnt_nxt = 3'd0;
                            w_state_nxt   = S_RDATA;
                        end else begin
                            w_state_nxt = S_IGNORE;
                            w_busy_nxt  = 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.sda_oe   = r_sda_oe;
    assign bus.reg_addr = r_reg_addr;
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_data  = r_wr_data;
    assign bus.rd_en    = r_rd_en;
    assign bus.busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_target_ctrl
//  Description : Directed I2C initiator with strobe scoreboard for the target.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_target_ctrl;

    localparam int Q = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m_scl = 1'b1;
    logic        m_sda = 1'b1;
    logic [7:0]  mem [256];
    int          n_pass = 0;
    int          n_total = 0;
    logic [15:0] wr_q [$];
    logic [7:0]  rd_q [$];
    logic [15:0] e_wr;
    logic [7:0]  e_rd;
    logic        prev_oe = 1'b0;
    logic        ack_n;
    logic [7:0]  rbyte;

    i2c_target_ctrl_if bus ();

    i2c_target_ctrl #(
        .TARGET_ADDR (7'h50),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.scl_i = m_scl;
    assign bus.sda_i = m_sda & ~bus.sda_oe;

    // Register file: data valid only in the cycle after rd_en.
    always @(posedge clk) begin
        bus.rd_data <= bus.rd_en ? mem[bus.reg_addr] : 8'hEE;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            check("wr_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
                e_wr = wr_q.pop_front();
                check("wr_addr", 32'(bus.reg_addr), 32'(e_wr[15:8]));
                check("wr_data", 32'(bus.wr_data), 32'(e_wr[7:0]));
            end
        end
        if (bus.rd_en === 1'b1) begin
            check("rd_expected", 32'(rd_q.size() != 0), 32'd1);
            if (rd_q.size() != 0) begin
                e_rd = rd_q.pop_front();
                check("rd_addr", 32'(bus.reg_addr), 32'(e_rd));
            end
        end
        if (bus.sda_oe !== prev_oe) begin
            check("oe_change_scl_low", 32'(m_scl), 32'd0);
        end
        prev_oe = bus.sda_oe;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b1; tick(Q);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;    tick(Q);
        m_scl = 1'b1; tick(2 * Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic a_n);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        a_n = bus.sda_i;
        tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            tick(Q);
            m_scl = 1'b1; tick(Q);
            d[i] = bus.sda_i;
            tick(Q);
            m_scl = 1'b0; tick(Q);
        end
        m_sda = nack; tick(Q);
        m_scl = 1'b1; tick(2 * Q);
        m_scl = 1'b0; tick(Q);
        m_sda = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h10] = 8'hC3;
        mem[8'h11] = 8'h3C;
        mem[8'h20] = 8'h6B;
        mem[8'h40] = 8'h35;

        rst = 1'b1;
        tick(4);
        check("rst_sda_oe",   32'(bus.sda_oe),   32'd0);
        check("rst_wr_en",    32'(bus.wr_en),    32'd0);
        check("rst_rd_en",    32'(bus.rd_en),    32'd0);
        check("rst_wr_data",  32'(bus.wr_data),  32'd0);
        check("rst_reg_addr", 32'(bus.reg_addr), 32'd0);
        check("rst_busy",     32'(bus.busy),     32'd0);
        rst = 1'b0;
        tick(Q);

        // Plain write of two data bytes
        wr_q.push_back({8'h03, 8'hA5});
        wr_q.push_back({8'h04, 8'h5A});
        i2c_start();
        write_byte(8'hA0, ack_n); check("w_addr_ack", 32'(ack_n), 32'd0);
        check("w_busy", 32'(bus.busy), 32'd1);
        write_byte(8'h03, ack_n); check("w_ptr_ack", 32'(ack_n), 32'd0);
        write_byte(8'hA5, ack_n); check("w_d0_ack", 32'(ack_n), 32'd0);
        write_byte(8'h5A, ack_n); check("w_d1_ack", 32'(ack_n), 32'd0);
        i2c_stop();
        check("w_final_ptr", 32'(bus.reg_addr), 32'h05);
        check("w_busy_stop", 32'(bus.busy), 32'd0);

        // Set pointer, repeated START, read two bytes (ACK then NACK)
        i2c_start();
        write_byte(8'hA0, ack_n); check("r_waddr_ack", 32'(ack_n), 32'd0);
        write_byte(8'h10, ack_n); check("r_ptr_ack", 32'(ack_n), 32'd0);
        rd_q.push_back(8'h10);
        rd_q.push_back(8'h11);
        i2c_start();
        write_byte(8'hA1, ack_n); check("r_raddr_ack", 32'(ack_n), 32'd0);
        read_byte(1'b0, rbyte); check("r_byte0", 32'(rbyte), 32'hC3);
        read_byte(1'b1, rbyte); check("r_byte1", 32'(rbyte), 32'h3C);
        check("r_oe_after_nack",   32'(bus.sda_oe),   32'd0);
        check("r_busy_after_nack", 32'(bus.busy),     32'd0);
        check("r_ptr_after_nack",  32'(bus.reg_addr), 32'h12);
        i2c_stop();

        // Address mismatch: never acknowledged, no strobes
        i2c_start();
        write_byte(8'hA2, ack_n); check("mm_addr_nack", 32'(ack_n), 32'd1);
        check("mm_busy", 32'(bus.busy), 32'd0);
        write_byte(8'h03, ack_n); check("mm_b1_nack", 32'(ack_n), 32'd1);
        write_byte(8'hFF, ack_n); check("mm_b2_nack", 32'(ack_n), 32'd1);
        check("mm_busy_end", 32'(bus.busy), 32'd0);
        i2c_stop();

        // Pointer wraps 0xFF -> 0x00
        wr_q.push_back({8'hFF, 8'h11});
        wr_q.push_back({8'h00, 8'h22});
        i2c_start();
        write_byte(8'hA0, ack_n); check("wrap_addr_ack", 32'(ack_n), 32'd0);
        write_byte(8'hFF, ack_n); check("wrap_ptr_ack", 32'(ack_n), 32'd0);
        write_byte(8'h11, ack_n); check("wrap_d0_ack", 32'(ack_n), 32'd0);
        write_byte(8'h22, ack_n); check("wrap_d1_ack", 32'(ack_n), 32'd0);
        i2c_stop();
        check("wrap_ptr", 32'(bus.reg_addr), 32'h01);

        // STOP after four bits of a data byte
        i2c_start();
        write_byte(8'hA0, ack_n); check("ab_addr_ack", 32'(ack_n), 32'd0);
        write_byte(8'h40, ack_n); check("ab_ptr_ack", 32'(ack_n), 32'd0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        i2c_stop();
        check("ab_ptr", 32'(bus.reg_addr), 32'h40);
        check("ab_busy", 32'(bus.busy), 32'd0);

        // Repeated START mid-byte, then read at the retained pointer
        i2c_start();
        write_byte(8'hA0, ack_n); check("sr_addr_ack", 32'(ack_n), 32'd0);
        write_byte(8'h20, ack_n); check("sr_ptr_ack", 32'(ack_n), 32'd0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        rd_q.push_back(8'h20);
        i2c_start();
        check("sr_ptr_kept", 32'(bus.reg_addr), 32'h20);
        write_byte(8'hA1, ack_n); check("sr_raddr_ack", 32'(ack_n), 32'd0);
        read_byte(1'b1, rbyte); check("sr_rbyte", 32'(rbyte), 32'h6B);
        check("sr_ptr_after", 32'(bus.reg_addr), 32'h21);
        i2c_stop();

        // Reset while driving a 0 bit of read data
        i2c_start();
        write_byte(8'hA0, ack_n); check("rr_waddr_ack", 32'(ack_n), 32'd0);
        write_byte(8'h40, ack_n); check("rr_ptr_ack", 32'(ack_n), 32'd0);
        rd_q.push_back(8'h40);
        i2c_start();
        write_byte(8'hA1, ack_n); check("rr_raddr_ack", 32'(ack_n), 32'd0);
        check("rr_oe_bit7", 32'(bus.sda_oe), 32'd1);
        #2 rst = 1'b1;
        #1 check("rr_oe_async", 32'(bus.sda_oe), 32'd0);
        tick(3);
        rst = 1'b0;
        check("rr_ptr_reset", 32'(bus.reg_addr), 32'd0);
        check("rr_busy_reset", 32'(bus.busy), 32'd0);
        m_scl = 1'b1;
        tick(Q);
        wr_q.push_back({8'h07, 8'h99});
        i2c_start();
        write_byte(8'hA0, ack_n); check("rw_addr_ack", 32'(ack_n), 32'd0);
        write_byte(8'h07, ack_n); check("rw_ptr_ack", 32'(ack_n), 32'd0);
        write_byte(8'h99, ack_n); check("rw_d0_ack", 32'(ack_n), 32'd0);
        i2c_stop();
        check("rw_ptr", 32'(bus.reg_addr), 32'h08);

        tick(Q);
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
